tile_reqmort_ingress: RTL and testbench



---
 rtl/tile_reqmort_ingress.sv | 183 ++++++++++++++++++
 tb/tb_tile_reqmort_ingress.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tile_reqmort_ingress.sv
// tile_reqmort_ingress: accepts line requests from the tile XY request FIFO's
// mortgage-output port, buffers them in a DEPTH-entry FIFO, and serialises each
// request into four 132-bit beats (one header-only beat for expunges) on a
// valid/ready port.
//
// Optional feature: define REQMORT_OVF_CNT_EN to build a saturating 16-bit
// dropped-push counter on ovf_cnt; otherwise ovf_cnt is tied to zero.
module tile_reqmort_ingress #(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned AF_LVL = DEPTH - 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [527:0] in_data,
    input  logic [36:0]  in_addr,
    input  logic [37:0]  in_size,
    input  logic         in_expun,
    output logic         in_afull,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [131:0] out_data,
    output logic [36:0]  out_addr,
    output logic [37:0]  out_size,
    output logic         out_expun,
    output logic [1:0]   out_beat,
    output logic         out_last,
    output logic         ovf,
    output logic [15:0]  ovf_cnt
);

    localparam int unsigned PW       = $clog2(DEPTH);
    localparam int unsigned EW       = 528 + 37 + 38 + 1;
    localparam int unsigned DATA_LSB = 76;
    localparam int unsigned ADDR_LSB = 39;
    localparam int unsigned SIZE_LSB = 1;

    localparam logic [PW:0] FULL_CNT = (PW + 1)'(DEPTH);
    localparam logic [PW:0] AF_CNT   = (PW + 1)'(AF_LVL);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;

    // Entry layout: {data, addr, size, expun}
    logic [EW-1:0] mem [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic [0:0]    state_q, state_d;
    logic [1:0]    beat_q, beat_d;
    logic          afull_q;
    logic          ovf_q;

    logic          full;
    logic          push;
    logic          drop;
    logic          pop;
    logic          sending;
    logic          last;
    logic [EW-1:0] head;

    // Full test uses the start-of-cycle count, so a same-cycle pop never frees a slot.
    assign full    = (count_q == FULL_CNT);
    assign push    = in_valid && !full;
    assign drop    = in_valid && full;
    assign head    = mem[rd_ptr_q];
    assign sending = (state_q == ST_SEND);
    assign last    = head[0] || (beat_q == 2'd3);
    assign pop     = sending && out_ready && last;

    // Pointer, count and serialiser next-state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        state_d  = state_q;
        beat_d   = beat_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + (PW + 1)'(1);
            2'b01:   count_d = count_q - (PW + 1)'(1);
            default: count_d = count_q;
        endcase

        case (state_q)
            ST_IDLE: begin
                if (count_q != '0) begin
                    state_d = ST_SEND;
                    beat_d  = 2'd0;
                end
            end
            default: begin
                if (out_ready) begin
                    if (last) begin
                        beat_d  = 2'd0;
                        // Post-pop count decides whether the next request follows with no bubble.
                        state_d = (count_d != '0) ? ST_SEND : ST_IDLE;
                    end else begin
                        beat_d = beat_q + 2'd1;
                    end
                end
            end
        endcase
    end

    // Control state; reset aborts any request in flight and empties the FIFO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            state_q  <= ST_IDLE;
            beat_q   <= 2'd0;
            afull_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            state_q  <= state_d;
            beat_q   <= beat_d;
            afull_q  <= (count_d >= AF_CNT);
            if (drop) begin
                ovf_q <= 1'b1;
            end
        end
    end

    // Request storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= {in_data, in_addr, in_size, in_expun};
        end
    end

`ifdef REQMORT_OVF_CNT_EN
    logic [15:0] ovf_cnt_q;

    // Saturating count of dropped pushes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_cnt_q <= 16'h0000;
        end else if (drop && (ovf_cnt_q != 16'hFFFF)) begin
            ovf_cnt_q <= ovf_cnt_q + 16'h0001;
        end
    end

    assign ovf_cnt = ovf_cnt_q;
`else
    assign ovf_cnt = 16'h0000;
`endif

    assign in_afull  = afull_q;
    assign ovf       = ovf_q;
    assign out_valid = sending;
    // Head fields are masked while idle so outputs read zero after reset.
    assign out_addr  = sending ? head[ADDR_LSB +: 37] : 37'd0;
    assign out_size  = sending ? head[SIZE_LSB +: 38] : 38'd0;
    assign out_expun = sending && head[0];
    assign out_beat  = beat_q;
    assign out_last  = sending && last;

    // Beat payload select; expunges carry no data.
    always_comb begin
        out_data = '0;
        if (sending && !head[0]) begin
            unique case (beat_q)
                2'd0: out_data = head[DATA_LSB +   0 +: 132];
                2'd1: out_data = head[DATA_LSB + 132 +: 132];
                2'd2: out_data = head[DATA_LSB + 264 +: 132];
                2'd3: out_data = head[DATA_LSB + 396 +: 132];
            endcase
        end
    end

endmodule

// File: tb/tb_tile_reqmort_ingress.sv
// Directed self-checking bench for tile_reqmort_ingress (DEPTH=8, AF_LVL=6).
module tb_tile_reqmort_ingress;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic [527:0] in_data;
    logic [36:0]  in_addr;
    logic [37:0]  in_size;
    logic         in_expun;
    logic         in_afull;
    logic         out_valid;
    logic         out_ready;
    logic [131:0] out_data;
    logic [36:0]  out_addr;
    logic [37:0]  out_size;
    logic         out_expun;
    logic [1:0]   out_beat;
    logic         out_last;
    logic         ovf;
    logic [15:0]  ovf_cnt;

    int total = 0;
    int bad   = 0;

    tile_reqmort_ingress dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_addr   (in_addr),
        .in_size   (in_size),
        .in_expun  (in_expun),
        .in_afull  (in_afull),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_addr  (out_addr),
        .out_size  (out_size),
        .out_expun (out_expun),
        .out_beat  (out_beat),
        .out_last  (out_last),
        .ovf       (ovf),
        .ovf_cnt   (ovf_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Byte i of request k is (k*16) ^ i; k = 0 gives incrementing bytes 0x00..0x41.
    function automatic logic [527:0] mk_data(input int k);
        logic [527:0] d;
        for (int i = 0; i < 66; i++) begin
            d[8*i +: 8] = 8'((k * 16) ^ i);
        end
        return d;
    endfunction

    function automatic logic [131:0] beat_of(input int k, input int b);
        logic [527:0] d;
        d = mk_data(k);
        return d[132*b +: 132];
    endfunction

    task automatic chk(input string tag, input logic [131:0] obs, input logic [131:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_req(input int k, input logic [36:0] a, input logic ex);
        in_valid = 1'b1;
        in_data  = mk_data(k);
        in_addr  = a;
        in_size  = 38'(k + 100);
        in_expun = ex;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, 132'(out_valid), 132'd0);
        chk({tag, "_data"},  out_data,        132'd0);
        chk({tag, "_addr"},  132'(out_addr),  132'd0);
        chk({tag, "_size"},  132'(out_size),  132'd0);
        chk({tag, "_expun"}, 132'(out_expun), 132'd0);
        chk({tag, "_beat"},  132'(out_beat),  132'd0);
        chk({tag, "_last"},  132'(out_last),  132'd0);
        chk({tag, "_afull"}, 132'(in_afull),  132'd0);
        chk({tag, "_ovf"},   132'(ovf),       132'd0);
        chk({tag, "_ovfcnt"}, 132'(ovf_cnt),  132'd0);
    endtask

    logic [15:0] exp_cnt;

    initial begin
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_addr   = '0;
        in_size   = '0;
        in_expun  = 1'b0;
        out_ready = 1'b0;
        #2 rst = 1'b1;
        repeat (2) step();
        chk_all_zero("reset");
        rst = 1'b0;
        step();

        // Single data request
        out_ready = 1'b1;
        push_req(0, 37'h1_2345_6780, 1'b0);
        step();
        in_valid = 1'b0;
        chk("lat_not_yet", 132'(out_valid), 132'd0);
        step();
        for (int b = 0; b < 4; b++) begin
            chk("single_valid", 132'(out_valid), 132'd1);
            chk("single_beat",  132'(out_beat),  132'(b));
            chk("single_last",  132'(out_last),  132'(b == 3));
            chk("single_data",  out_data,        beat_of(0, b));
            chk("single_addr",  132'(out_addr),  132'h1_2345_6780);
            step();
        end
        chk("single_done", 132'(out_valid), 132'd0);

        // Expunge
        push_req(1, 37'h55, 1'b1);
        step();
        in_valid = 1'b0;
        step();
        chk("exp_valid", 132'(out_valid), 132'd1);
        chk("exp_last",  132'(out_last),  132'd1);
        chk("exp_expun", 132'(out_expun), 132'd1);
        chk("exp_data",  out_data,        132'd0);
        chk("exp_addr",  132'(out_addr),  132'h55);
        step();
        chk("exp_done",  132'(out_valid), 132'd0);
        step();
        chk("exp_empty", 132'(out_valid), 132'd0);

        // Backpressure: fill with out_ready low
        out_ready = 1'b0;
        for (int k = 0; k < 8; k++) begin
            push_req(k + 2, 37'(k + 2), 1'b0);
            step();
            chk("bp_afull", 132'(in_afull), 132'(k >= 5));
            if (k >= 1) begin
                chk("bp_stall_data", out_data,        beat_of(2, 0));
                chk("bp_stall_addr", 132'(out_addr),  132'd2);
                chk("bp_stall_beat", 132'(out_beat),  132'd0);
                chk("bp_stall_vld",  132'(out_valid), 132'd1);
            end
        end
        chk("bp_no_ovf", 132'(ovf), 132'd0);
        push_req(99, 37'h99, 1'b0);
        step();
        in_valid = 1'b0;
        chk("bp_ovf", 132'(ovf), 132'd1);
`ifdef REQMORT_OVF_CNT_EN
        exp_cnt = 16'd1;
`else
        exp_cnt = 16'd0;
`endif
        chk("bp_ovf_cnt", 132'(ovf_cnt), 132'(exp_cnt));

        // Drain in push order with periodic stalls
        for (int k = 0; k < 8; k++) begin
            for (int b = 0; b < 4; b++) begin
                chk("drain_valid", 132'(out_valid), 132'd1);
                chk("drain_addr",  132'(out_addr),  132'(k + 2));
                chk("drain_size",  132'(out_size),  132'(k + 102));
                chk("drain_beat",  132'(out_beat),  132'(b));
                chk("drain_last",  132'(out_last),  132'(b == 3));
                chk("drain_data",  out_data,        beat_of(k + 2, b));
                if (((k + b) % 3) == 0) begin
                    out_ready = 1'b0;
                    step();
                    chk("stall_data", out_data,       beat_of(k + 2, b));
                    chk("stall_beat", 132'(out_beat), 132'(b));
                    chk("stall_addr", 132'(out_addr), 132'(k + 2));
                    chk("stall_last", 132'(out_last), 132'(b == 3));
                end
                out_ready = 1'b1;
                step();
            end
        end
        chk("drain_done", 132'(out_valid), 132'd0);

        // Push on the same edge as the last-beat pop with count = 1
        push_req(20, 37'h20, 1'b0);
        step();
        in_valid = 1'b0;
        step();
        step();
        step();
        step();
        chk("coll_pre_beat", 132'(out_beat), 132'd3);
        chk("coll_pre_addr", 132'(out_addr), 132'h20);
        push_req(21, 37'h21, 1'b0);
        step();
        in_valid = 1'b0;
        chk("coll_valid", 132'(out_valid), 132'd1);
        chk("coll_beat",  132'(out_beat),  132'd0);
        chk("coll_addr",  132'(out_addr),  132'h21);
        chk("coll_data",  out_data,        beat_of(21, 0));
        step();
        step();
        step();
        chk("coll_last", 132'(out_last), 132'd1);
        step();
        chk("coll_cnt1", 132'(out_valid), 132'd0);

        // Asynchronous reset during beat 2
        push_req(22, 37'h22, 1'b0);
        step();
        in_valid = 1'b0;
        step();
        step();
        step();
        chk("rst_pre_beat", 132'(out_beat), 132'd2);
        #1 rst = 1'b1;
        #1;
        chk_all_zero("rst_mid");
        #1 rst = 1'b0;
        step();
        chk("rst_idle1", 132'(out_valid), 132'd0);
        step();
        chk("rst_idle2", 132'(out_valid), 132'd0);
        push_req(23, 37'h23, 1'b0);
        step();
        in_valid = 1'b0;
        step();
        chk("rst_new_valid", 132'(out_valid), 132'd1);
        chk("rst_new_addr",  132'(out_addr),  132'h23);
        chk("rst_new_beat",  132'(out_beat),  132'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
